// File: rtl/inst_fetch.sv
// inst_fetch: single-stage instruction fetch unit.
//
// Drives a word address to a combinational instruction ROM and captures the
// returned word into a one-entry output register with a valid/ready handshake
// towards decode. Supports branch/jump redirects, which flush the output
// register and have top priority. It can also stop fetching when the ROM
// returns an all-zero word, which marks an unprogrammed slot.
//
// Parameters:
//   RESET_PC        word address fetched first after reset
//   HALT_ON_ZERO    1: a fetched 32'd0 moves fetch into HALTED
//
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   address          [31:0] word address to ROM (the pc register)
//   inst             [31:0] ROM data for address, same cycle
//   out_inst         [31:0] instruction presented to decode
//   out_pc           [31:0] word address of out_inst
//   out_valid        out_inst/out_pc hold a valid instruction
//   out_ready        decode accepts the output this cycle
//   redirect_en      branch/jump request
//   redirect_target  [31:0] redirect word address
//   halted           fetch is in HALTED
//   issue_count      [15:0] instructions loaded into the output register
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] address,
  input  logic [31:0] inst,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic [15:0] issue_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] count_q, count_d;
  logic        halted_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;

    if (redirect_en) begin
      // Flush regardless of out_ready; the new target is fetched next cycle.
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          if (out_ready) out_valid_d = 1'b0;
        end
        RUN: begin
          // Output slot is free when empty or being consumed this cycle.
          if (!out_valid_q || out_ready) begin
            if (HALT_ON_ZERO && (inst == '0)) begin
              // No load: the slot is either empty or drains now.
              state_d     = HALTED;
              out_valid_d = 1'b0;
            end else begin
              out_inst_d  = inst;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              pc_d        = pc_q + 32'd1;
              count_d     = count_q + 16'd1;
            end
          end
        end
        HALTED: begin
          if (out_ready) out_valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      halted_q    <= (state_d == HALTED);
    end
  end

  assign address     = pc_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_valid   = out_valid_q;
  assign issue_count = count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] address;
  logic [31:0] inst;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halted;
  logic [15:0] issue_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom_mem [64];

  inst_fetch #(
    .RESET_PC    (32'd0),
    .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .inst           (inst),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .redirect_en    (redirect_en),
    .redirect_target(redirect_target),
    .halted         (halted),
    .issue_count    (issue_count)
  );

  always #5 clk = ~clk;

  // ROM: 64 programmable words; every address beyond is a nonzero pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd64) return rom_mem[a[5:0]];
    return {a[30:0], 1'b1};
  endfunction

  always_comb inst = rom_word(address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an output slot plus a fetch pointer. The slot frees
  // when empty or consumed; a free slot takes the next ROM word unless fetch
  // is warming up after reset, stopped on a zero word, or being redirected.
  logic [31:0] m_pc, m_inst, m_opc;
  logic        m_valid, m_warmup, m_stopped;
  logic [15:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'd0; m_inst = '0; m_opc = '0; m_valid = 1'b0;
      m_warmup = 1'b1; m_stopped = 1'b0; m_count = '0;
    end else begin
      logic slot_free;
      logic [31:0] w;
      slot_free = !m_valid || out_ready;
      w = rom_word(m_pc);
      if (redirect_en) begin
        m_pc = redirect_target; m_valid = 1'b0;
        m_warmup = 1'b0; m_stopped = 1'b0;
      end else if (m_warmup || m_stopped || (slot_free && w == 32'd0)) begin
        if (!m_warmup && !m_stopped) m_stopped = 1'b1;
        m_warmup = 1'b0;
        if (out_ready) m_valid = 1'b0;
      end else if (slot_free) begin
        m_inst = w; m_opc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 32'd1; m_count = m_count + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_address", address, m_pc);
      chk("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("m_halted", {31'd0, halted}, {31'd0, m_stopped});
      chk("m_count", {16'd0, issue_count}, {16'd0, m_count});
      if (m_valid) begin
        chk("m_out_pc", out_pc, m_opc);
        chk("m_out_inst", out_inst, m_inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_pc"}, out_pc, pc);
  endtask

  initial begin
    for (int unsigned i = 0; i < 64; i++)
      rom_mem[i] = (i < 16) ? 32'h1000_0000 + i : 32'h2000_0000 + i;
    rom_mem[16] = 32'd0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_count", {16'd0, issue_count}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Warm-up cycle, then 0..3 back to back
    tick(); chk("warm_valid", {31'd0, out_valid}, 32'd0);
    tick(); expect_out("seq0", 32'd0); chk("seq0_inst", out_inst, 32'h1000_0000);
    tick(); expect_out("seq1", 32'd1);
    tick(); expect_out("seq2", 32'd2);
    tick(); expect_out("seq3", 32'd3); chk("seq3_count", {16'd0, issue_count}, 32'd4);
    tick(); tick(); expect_out("at5", 32'd5);

    // Stall three cycles at out_pc=5
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 32'd5);
      chk("stall_inst", out_inst, 32'h1000_0005);
      chk("stall_addr", address, 32'd6);
    end
    out_ready = 1'b1;
    tick(); expect_out("release", 32'd6);
    tick(); expect_out("at7", 32'd7);

    // Redirect while stalled
    out_ready = 1'b0; redirect_en = 1'b1; redirect_target = 32'd12;
    tick(); chk("flush_valid", {31'd0, out_valid}, 32'd0); chk("flush_addr", address, 32'd12);
    redirect_en = 1'b0; out_ready = 1'b1;
    tick(); expect_out("tgt12", 32'd12);
    tick(); tick(); tick(); expect_out("at15", 32'd15);

    // Zero word at 16 halts fetch
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, out_valid}, 32'd0);
      chk("halt_addr", address, 32'd16);
    end
    redirect_en = 1'b1; redirect_target = 32'd0;
    tick(); chk("unhalt_flag", {31'd0, halted}, 32'd0); chk("unhalt_valid", {31'd0, out_valid}, 32'd0);
    redirect_en = 1'b0;
    tick(); expect_out("unhalt_pc0", 32'd0);

    // pc wrap
    redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFF;
    tick(); redirect_en = 1'b0;
    tick(); expect_out("wrap_top", 32'hFFFF_FFFF); chk("wrap_inst", out_inst, 32'hFFFF_FFFF);
    tick(); expect_out("wrap_zero", 32'd0); chk("wrap_addr", address, 32'd1);

    // Asynchronous reset mid-stream
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    chk("arst_count", {16'd0, issue_count}, 32'd0);
    chk("arst_addr", address, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick(); chk("rewarm_valid", {31'd0, out_valid}, 32'd0);
    tick(); expect_out("restart", 32'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 64; i++)
      rom_mem[i] = ($urandom_range(0, 11) == 0) ? 32'd0 : $urandom | 32'd1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_target = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else
        redirect_target = $urandom_range(0, 63);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'd0, meaning the word address fetched first after reset.
REQ-002 The module SHALL have parameter HALT_ON_ZERO, default 1, meaning a fetched word of 32'd0 (unprogrammed ROM slot) stops fetch.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port address, output, 32 bits: word address to the instruction ROM.
REQ-006 The module SHALL have port inst, input, 32 bits: combinational ROM data for the current address.
REQ-007 The module SHALL have port out_inst, output, 32 bits: instruction presented to decode.
REQ-008 The module SHALL have port out_pc, output, 32 bits: word address of out_inst.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_inst/out_pc hold a valid instruction.
REQ-010 The module SHALL have port out_ready, input, 1 bit: decode accepts the output this cycle.
REQ-011 The module SHALL have port redirect_en, input, 1 bit: branch/jump request.
REQ-012 The module SHALL have port redirect_target, input, 32 bits: word address for the redirect.
REQ-013 The module SHALL have port halted, output, 1 bit: fetch is in the HALTED state.
REQ-014 The module SHALL have port issue_count, output, 16 bits: number of instructions loaded into the output register.

Function
REQ-015 address SHALL equal the internal pc register combinationally; inst SHALL be sampled in the same cycle.
REQ-016 State machine SHALL have states IDLE, RUN, HALTED; IDLE SHALL go to RUN unconditionally after exactly one cycle.
REQ-017 In RUN, a load SHALL occur when out_valid==0 or out_ready==1: out_inst<=inst, out_pc<=pc, out_valid<=1, pc<=pc+1, issue_count<=issue_count+1.
REQ-018 out_valid==1 with out_ready==0 SHALL hold pc, out_inst, out_pc, out_valid and issue_count unchanged (stall).
REQ-019 When no load occurs and out_ready==1, out_valid SHALL clear to 0.
REQ-020 With HALT_ON_ZERO==1, a load cycle with inst==32'd0 SHALL NOT load; state SHALL go to HALTED, pc SHALL hold, and a pending valid output SHALL still drain normally.
REQ-021 In IDLE and HALTED, no load SHALL occur; halted SHALL be 1 only in HALTED.
REQ-022 redirect_en SHALL have top priority in any state: pc<=redirect_target, out_valid<=0 (flush, regardless of out_ready), state<=RUN, no load that cycle.
REQ-023 pc+1 SHALL wrap modulo 2^32 (32'hFFFFFFFF -> 0); issue_count SHALL wrap modulo 2^16.
REQ-024 Latency SHALL be one cycle from pc driving address to the instruction appearing on out_inst.
REQ-025 With out_ready held at 1 in RUN, one instruction SHALL issue per cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately set pc=RESET_PC, out_inst=0, out_pc=0, out_valid=0, issue_count=0, state=IDLE, halted=0, including mid-stall or mid-redirect.
REQ-027 The first load after rst_n rises SHALL occur on the second rising edge, fetching RESET_PC.

Verification
REQ-028 Reset release, out_ready=1, ROM words 0..3 nonzero -> out_pc = 0,1,2,3 on consecutive cycles starting at cycle 2, issue_count = 4.
REQ-029 out_valid=1 at out_pc=5, out_ready=0 for 3 cycles -> out_inst/out_pc/address frozen; on release, out_pc=6 next cycle.
REQ-030 redirect_en=1 with target 32'd12 while stalled at out_pc=7 -> out_valid=0 next cycle, then out_pc=12 the following cycle.
REQ-031 ROM word 16 = 0 (16-word ROM run from 0) -> out_pc=15 issues, halted=1, address holds 16, no further out_valid; redirect to 0 -> halted=0, out_pc=0 issues.
REQ-032 redirect to 32'hFFFFFFFF -> out_pc=32'hFFFFFFFF then out_pc=0.
REQ-033 rst_n pulsed low asynchronously mid-stream with out_valid=1 -> all outputs zero before the next clock edge; restart per REQ-027.
